// File: rtl/picoriscv_mem_sequencer.sv
// Memory sequencer for the picoriscv core: shares one SRAM port between ifetch and dmem, and runs the IO bus handshake.
// Optional IO timeout watchdog is enabled by defining PICORISCV_MEM_IO_TIMEOUT_EN.
module picoriscv_mem_sequencer #(
    parameter int IO_TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_dmem_request,
    input  logic        mem_ifetch_request,
    input  logic        mem_dmem_set_reg,
    input  logic        mem_ifetch_set_reg,
    input  logic        mem_ifetch_use_reg,
    input  logic        mem_io_enable,
    input  logic [31:0] ifetch_address,
    input  logic [31:0] dmem_address,
    input  logic        dmem_read_enable,
    input  logic        dmem_write_enable,
    input  logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_write_data,
    input  logic [31:0] sram_read_data,
    output logic        sram_enable,
    output logic        sram_write,
    output logic [13:0] sram_address,
    output logic [3:0]  sram_byte_enable,
    output logic [31:0] sram_write_data,
    output logic [31:0] ifetch_data,
    output logic [31:0] dmem_read_data,
    output logic        io_req,
    input  logic        io_ack,
    input  logic [31:0] io_read_data,
    output logic        clock_status_io_request,
    output logic        clock_status_io_ready,
    output logic        io_timeout_error
);

    typedef enum logic [1:0] {
        IO_IDLE = 2'd0,
        IO_REQ  = 2'd1,
        IO_DONE = 2'd2
    } io_state_e;

    // A limit outside 1..255 cannot be represented by the 8-bit watchdog counter.
    if (IO_TIMEOUT_CYCLES < 1 || IO_TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("IO_TIMEOUT_CYCLES must be in 1..255");
    end

    io_state_e   io_state_q, io_state_d;
    logic [31:0] ifetch_reg_q, ifetch_reg_d;
    logic [31:0] dmem_reg_q, dmem_reg_d;
    logic [31:0] io_data_q, io_data_d;
    logic        dmem_access_s, dmem_sram_s, dmem_io_s, io_read_s;
    logic        unused_addr_bits_s;

    assign dmem_access_s = dmem_read_enable | dmem_write_enable;
    assign dmem_sram_s   = ~dmem_address[31] & dmem_access_s;
    assign dmem_io_s     = dmem_address[31] & dmem_access_s;
    assign io_read_s     = dmem_address[31] & dmem_read_enable;

    assign unused_addr_bits_s = ^{ifetch_address[31:16], ifetch_address[1:0],
                                  dmem_address[30:16], dmem_address[1:0]};

`ifdef PICORISCV_MEM_IO_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(IO_TIMEOUT_CYCLES - 1);
    logic [7:0] timeout_cnt_q, timeout_cnt_d;
    logic       io_timeout_error_q, io_timeout_error_d;
`endif

    // SRAM port arbitration: dmem wins the address when both sides request.
    always_comb begin
        sram_enable      = 1'b0;
        sram_write       = 1'b0;
        sram_address     = 14'd0;
        sram_byte_enable = 4'hF;
        sram_enable = (mem_dmem_request & dmem_sram_s) | mem_ifetch_request;
        sram_write  = mem_dmem_request & dmem_sram_s & dmem_write_enable;
        if (mem_dmem_request) begin
            sram_address = dmem_address[15:2];
        end else begin
            sram_address = ifetch_address[15:2];
        end
        if (sram_write) begin
            sram_byte_enable = dmem_byte_enable;
        end else begin
            sram_byte_enable = 4'hF;
        end
    end

    assign sram_write_data = dmem_write_data;

    // Read-data holding registers for ifetch and SRAM-side dmem reads.
    always_comb begin
        ifetch_reg_d = ifetch_reg_q;
        dmem_reg_d   = dmem_reg_q;
        if (mem_ifetch_set_reg) begin
            ifetch_reg_d = sram_read_data;
        end else begin
            ifetch_reg_d = ifetch_reg_q;
        end
        if (mem_dmem_set_reg && dmem_sram_s) begin
            dmem_reg_d = sram_read_data;
        end else begin
            dmem_reg_d = dmem_reg_q;
        end
    end

    assign ifetch_data    = mem_ifetch_use_reg ? ifetch_reg_q : sram_read_data;
    assign dmem_read_data = dmem_io_s ? io_data_q : dmem_reg_q;

    // IO handshake FSM next-state; once issued, a request is only ended by io_ack, timeout or reset.
    always_comb begin
        io_state_d = io_state_q;
        io_data_d  = io_data_q;
`ifdef PICORISCV_MEM_IO_TIMEOUT_EN
        timeout_cnt_d      = timeout_cnt_q;
        io_timeout_error_d = io_timeout_error_q;
`endif
        case (io_state_q)
            IO_IDLE: begin
                if (mem_io_enable && dmem_io_s) begin
                    io_state_d = IO_REQ;
`ifdef PICORISCV_MEM_IO_TIMEOUT_EN
                    timeout_cnt_d = 8'd0;
`endif
                end else begin
                    io_state_d = IO_IDLE;
                end
            end
            IO_REQ: begin
                if (io_ack) begin
                    io_state_d = IO_DONE;
                    if (io_read_s) begin
                        io_data_d = io_read_data;
                    end else begin
                        io_data_d = io_data_q;
                    end
`ifdef PICORISCV_MEM_IO_TIMEOUT_EN
                end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                    io_state_d         = IO_DONE;
                    io_data_d          = 32'hDEAD_DEAD;
                    io_timeout_error_d = 1'b1;
                end else begin
                    timeout_cnt_d = timeout_cnt_q + 8'd1;
`else
                end else begin
                    io_state_d = IO_REQ;
`endif
                end
            end
            IO_DONE: begin
                if (!mem_io_enable) begin
                    io_state_d = IO_IDLE;
                end else begin
                    io_state_d = IO_DONE;
                end
            end
            default: begin
                io_state_d = IO_IDLE;
            end
        endcase
    end

    // State and data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            io_state_q   <= IO_IDLE;
            ifetch_reg_q <= 32'd0;
            dmem_reg_q   <= 32'd0;
            io_data_q    <= 32'd0;
        end else begin
            io_state_q   <= io_state_d;
            ifetch_reg_q <= ifetch_reg_d;
            dmem_reg_q   <= dmem_reg_d;
            io_data_q    <= io_data_d;
        end
    end

`ifdef PICORISCV_MEM_IO_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt_q      <= 8'd0;
            io_timeout_error_q <= 1'b0;
        end else begin
            timeout_cnt_q      <= timeout_cnt_d;
            io_timeout_error_q <= io_timeout_error_d;
        end
    end

    assign io_timeout_error = io_timeout_error_q;
`else
    assign io_timeout_error = 1'b0;
`endif

    assign io_req                  = (io_state_q == IO_REQ);
    assign clock_status_io_request = dmem_io_s;
    assign clock_status_io_ready   = (io_state_q == IO_DONE);

endmodule

// File: tb/tb_picoriscv_mem_sequencer.sv
// Directed bench for picoriscv_mem_sequencer: SRAM arbitration table plus hand-written IO / register sequences.
module tb_picoriscv_mem_sequencer;

    logic        clk;
    logic        reset_n;
    logic        mem_dmem_request, mem_ifetch_request;
    logic        mem_dmem_set_reg, mem_ifetch_set_reg, mem_ifetch_use_reg;
    logic        mem_io_enable;
    logic [31:0] ifetch_address, dmem_address;
    logic        dmem_read_enable, dmem_write_enable;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_write_data, sram_read_data;
    logic        sram_enable, sram_write;
    logic [13:0] sram_address;
    logic [3:0]  sram_byte_enable;
    logic [31:0] sram_write_data, ifetch_data, dmem_read_data;
    logic        io_req, io_ack;
    logic [31:0] io_read_data;
    logic        clock_status_io_request, clock_status_io_ready, io_timeout_error;

    int tests_run;
    int tests_failed;
    int hi_cnt;

    picoriscv_mem_sequencer #(.IO_TIMEOUT_CYCLES(4)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .mem_dmem_request        (mem_dmem_request),
        .mem_ifetch_request      (mem_ifetch_request),
        .mem_dmem_set_reg        (mem_dmem_set_reg),
        .mem_ifetch_set_reg      (mem_ifetch_set_reg),
        .mem_ifetch_use_reg      (mem_ifetch_use_reg),
        .mem_io_enable           (mem_io_enable),
        .ifetch_address          (ifetch_address),
        .dmem_address            (dmem_address),
        .dmem_read_enable        (dmem_read_enable),
        .dmem_write_enable       (dmem_write_enable),
        .dmem_byte_enable        (dmem_byte_enable),
        .dmem_write_data         (dmem_write_data),
        .sram_read_data          (sram_read_data),
        .sram_enable             (sram_enable),
        .sram_write              (sram_write),
        .sram_address            (sram_address),
        .sram_byte_enable        (sram_byte_enable),
        .sram_write_data         (sram_write_data),
        .ifetch_data             (ifetch_data),
        .dmem_read_data          (dmem_read_data),
        .io_req                  (io_req),
        .io_ack                  (io_ack),
        .io_read_data            (io_read_data),
        .clock_status_io_request (clock_status_io_request),
        .clock_status_io_ready   (clock_status_io_ready),
        .io_timeout_error        (io_timeout_error)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        req_d;
        logic        req_i;
        logic        rd;
        logic        wr;
        logic [31:0] daddr;
        logic [31:0] iaddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_en;
        logic        exp_wr;
        logic [13:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset_n = 1'b0;
        mem_dmem_request = 1'b0; mem_ifetch_request = 1'b0;
        mem_dmem_set_reg = 1'b0; mem_ifetch_set_reg = 1'b0; mem_ifetch_use_reg = 1'b1;
        mem_io_enable = 1'b0;
        ifetch_address = 32'd0; dmem_address = 32'd0;
        dmem_read_enable = 1'b0; dmem_write_enable = 1'b0;
        dmem_byte_enable = 4'h0; dmem_write_data = 32'd0;
        sram_read_data = 32'hFFFF_FFFF;
        io_ack = 1'b0; io_read_data = 32'd0;

        //              name          rq_d  rq_i  rd    wr    daddr          iaddr          be     wdata          en    wr    addr      be
        vecs[0] = '{"ifetch_only",   1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0040, 4'h0,  32'h0,         1'b1, 1'b0, 14'h010,  4'hF};
        vecs[1] = '{"sram_write",    1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_0000, 4'h3,  32'h0000_1234, 1'b1, 1'b1, 14'h002,  4'h3};
        vecs[2] = '{"dmem_prio",     1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0040, 4'h5,  32'h0,         1'b1, 1'b0, 14'h041,  4'hF};
        vecs[3] = '{"io_wr_no_sram", 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0010, 32'h0000_0040, 4'h3,  32'hABCD_0000, 1'b0, 1'b0, 14'h004,  4'hF};
        vecs[4] = '{"io_wr_ifetch",  1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0010, 32'h0000_0040, 4'h3,  32'h0,         1'b1, 1'b0, 14'h004,  4'hF};
        vecs[5] = '{"no_request",    1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_1234, 4'h1,  32'h0,         1'b0, 1'b0, 14'h48D,  4'hF};
        vecs[6] = '{"dmem_no_rdwr",  1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0040, 4'hF,  32'h0,         1'b0, 1'b0, 14'h008,  4'hF};
        vecs[7] = '{"top_word_wr",   1'b1, 1'b0, 1'b0, 1'b1, 32'h0001_FFFC, 32'h0000_0040, 4'hC,  32'h5A5A_0001, 1'b1, 1'b1, 14'h3FFF, 4'hC};

        // Reset state while reset_n is held low.
        step();
        chk("rst_io_req", {31'd0, io_req}, 32'd0);
        chk("rst_io_ready", {31'd0, clock_status_io_ready}, 32'd0);
        chk("rst_timeout_err", {31'd0, io_timeout_error}, 32'd0);
        chk("rst_ifetch_reg", ifetch_data, 32'd0);
        chk("rst_dmem_reg", dmem_read_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ifetch_use_reg = 1'b0;

        // Combinational SRAM arbitration table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_dmem_request = vecs[i].req_d; mem_ifetch_request = vecs[i].req_i;
            dmem_read_enable = vecs[i].rd;    dmem_write_enable = vecs[i].wr;
            dmem_address = vecs[i].daddr;     ifetch_address = vecs[i].iaddr;
            dmem_byte_enable = vecs[i].be;    dmem_write_data = vecs[i].wdata;
            #1;
            chk({vecs[i].name, "_en"}, {31'd0, sram_enable}, {31'd0, vecs[i].exp_en});
            chk({vecs[i].name, "_wr"}, {31'd0, sram_write}, {31'd0, vecs[i].exp_wr});
            chk({vecs[i].name, "_addr"}, {18'd0, sram_address}, {18'd0, vecs[i].exp_addr});
            chk({vecs[i].name, "_be"}, {28'd0, sram_byte_enable}, {28'd0, vecs[i].exp_be});
            chk({vecs[i].name, "_wdata"}, sram_write_data, vecs[i].wdata);
        end

        // Instruction fetch passthrough on the cycle after presentation.
        @(negedge clk);
        mem_dmem_request = 1'b0; dmem_read_enable = 1'b0; dmem_write_enable = 1'b0;
        ifetch_address = 32'h40; mem_ifetch_request = 1'b1;
        #1;
        chk("ifetch_addr", {18'd0, sram_address}, 32'h010);
        @(negedge clk);
        mem_ifetch_request = 1'b0; sram_read_data = 32'h0000_0013;
        #1;
        chk("ifetch_data", ifetch_data, 32'h0000_0013);

        // SRAM dmem read captured by set_reg and held afterwards.
        @(negedge clk);
        dmem_address = 32'h104; dmem_read_enable = 1'b1; mem_dmem_request = 1'b1;
        @(negedge clk);
        mem_dmem_request = 1'b0; mem_dmem_set_reg = 1'b1; sram_read_data = 32'hCAFE_F00D;
        @(negedge clk);
        mem_dmem_set_reg = 1'b0; sram_read_data = 32'h1111_1111;
        #1;
        chk("dmem_rd", dmem_read_data, 32'hCAFE_F00D);
        step();
        chk("dmem_rd_held", dmem_read_data, 32'hCAFE_F00D);

        // set_reg on an IO address must not disturb dmem_reg.
        dmem_address = 32'h8000_0104; mem_dmem_set_reg = 1'b1; sram_read_data = 32'h2222_2222;
        @(negedge clk);
        mem_dmem_set_reg = 1'b0; dmem_address = 32'h104;
        #1;
        chk("dmem_io_no_cap", dmem_read_data, 32'hCAFE_F00D);

        // ifetch register capture and replay.
        mem_ifetch_set_reg = 1'b1; sram_read_data = 32'h00A0_0093;
        @(negedge clk);
        mem_ifetch_set_reg = 1'b0; mem_ifetch_use_reg = 1'b1; sram_read_data = 32'h3333_3333;
        #1;
        chk("ifetch_reg", ifetch_data, 32'h00A0_0093);
        mem_ifetch_use_reg = 1'b0;
        dmem_read_enable = 1'b0;

        // IO read: ack after three REQ cycles.
        @(negedge clk);
        dmem_address = 32'h8000_0000; dmem_read_enable = 1'b1; mem_io_enable = 1'b1;
        #1;
        chk("io_rd_status_req", {31'd0, clock_status_io_request}, 32'd1);
        chk("io_rd_idle_req", {31'd0, io_req}, 32'd0);
        hi_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (io_req) hi_cnt++;
        end
        io_ack = 1'b1; io_read_data = 32'h55AA_55AA;
        step();
        chk("io_rd_req_cycles", hi_cnt, 32'd3);
        chk("io_rd_req_off", {31'd0, io_req}, 32'd0);
        chk("io_rd_ready", {31'd0, clock_status_io_ready}, 32'd1);
        chk("io_rd_data", dmem_read_data, 32'h55AA_55AA);
        io_read_data = 32'h1234_5678;
        step();
        chk("io_done_stays", {31'd0, clock_status_io_ready}, 32'd1);
        chk("io_done_no_reissue", {31'd0, io_req}, 32'd0);
        chk("io_done_ack_ignored", dmem_read_data, 32'h55AA_55AA);
        io_ack = 1'b0; mem_io_enable = 1'b0;
        step();
        chk("io_idle_ready", {31'd0, clock_status_io_ready}, 32'd0);
        step();
        chk("io_idle_no_req", {31'd0, io_req}, 32'd0);

        // IO write: ack completes but does not load read data.
        dmem_read_enable = 1'b0; dmem_write_enable = 1'b1; dmem_address = 32'h8000_0004;
        mem_io_enable = 1'b1; io_read_data = 32'h9999_9999;
        step();
        chk("io_wr_req", {31'd0, io_req}, 32'd1);
        io_ack = 1'b1;
        step();
        io_ack = 1'b0;
        chk("io_wr_ready", {31'd0, clock_status_io_ready}, 32'd1);
        chk("io_wr_data_kept", dmem_read_data, 32'h55AA_55AA);
        mem_io_enable = 1'b0;
        step();
        chk("io_wr_idle", {31'd0, clock_status_io_ready}, 32'd0);

        // dmem_io dropping inside REQ does not abort the request.
        dmem_write_enable = 1'b0; dmem_read_enable = 1'b1; dmem_address = 32'h8000_0000;
        mem_io_enable = 1'b1;
        step();
        dmem_read_enable = 1'b0;
        hi_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (io_req) hi_cnt++;
        end
        chk("io_drop_still_req", hi_cnt, 32'd3);
        io_ack = 1'b1;
        step();
        io_ack = 1'b0;
        chk("io_drop_done", {31'd0, clock_status_io_ready}, 32'd1);
        mem_io_enable = 1'b0;
        step();
        chk("io_drop_idle", {31'd0, clock_status_io_ready}, 32'd0);

        // No ack: watchdog completion when enabled, otherwise REQ persists.
        dmem_read_enable = 1'b1; dmem_address = 32'h8000_0000; mem_io_enable = 1'b1;
        hi_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (io_req) hi_cnt++;
        end
`ifdef PICORISCV_MEM_IO_TIMEOUT_EN
        chk("tmo_req_cycles", hi_cnt, 32'd4);
        chk("tmo_ready", {31'd0, clock_status_io_ready}, 32'd1);
        chk("tmo_data", dmem_read_data, 32'hDEAD_DEAD);
        chk("tmo_err", {31'd0, io_timeout_error}, 32'd1);
`else
        chk("notmo_req_cycles", hi_cnt, 32'd10);
        chk("notmo_err", {31'd0, io_timeout_error}, 32'd0);
`endif

        // Asynchronous reset abandons the transaction.
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", {31'd0, io_req}, 32'd0);
        chk("rst_mid_ready", {31'd0, clock_status_io_ready}, 32'd0);
        chk("rst_mid_err", {31'd0, io_timeout_error}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1; mem_io_enable = 1'b0; io_ack = 1'b1;
        step();
        chk("post_rst_req", {31'd0, io_req}, 32'd0);
        chk("post_rst_ready", {31'd0, clock_status_io_ready}, 32'd0);
        io_ack = 1'b0; mem_io_enable = 1'b1;
        step();
        chk("post_rst_reissue", {31'd0, io_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
